// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the bit-period helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit. Integer division on purpose, so the receiver computes
  // the identical period from the same two parameters.
  function automatic int pulse_width(input int clk_speed, input int baud_rate);
    return clk_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter: loads a value, counts to zero, flags done while at zero.
// Latency: done_o is high on the cycle the count reads zero (load_val_i+1 cycles after load_i).
// Backpressure: none; load_i wins over counting on the same edge.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   load_i, load_val_i  restart the count from load_val_i
//   done_o              count is zero (current bit period is ending)
module uart_baud_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_alt.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
// Latency: handshake at edge k drives the start bit from edge k+1 when idle.
// Backpressure: one-entry holding register; ready_o drops while it is full.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   data_i, valid_i     byte stream in; captured when valid_i && ready_o
//   ready_o             holding register empty
//   txd_o               registered serial line, idle high
//   busy_o              frame in flight or byte held
module uart_tx_alt
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 38400,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_SPEED  = 12_000_000,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  txd_o,
  output logic                  busy_o
);

  localparam int PULSE_WIDTH = pulse_width(CLK_SPEED, BAUD_RATE);
  localparam int STOP_LEN    = STOP_BITS * PULSE_WIDTH;
  // Sized for the whole stop period, which is longer than one bit with two stop bits.
  localparam int CNT_W       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic                  txd_q, txd_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             load_frame;
  logic             accept;

  uart_baud_timer #(.CNT_W(CNT_W)) u_baud_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign ready_o = !hold_vld_q;
  assign busy_o  = (state_q != IDLE) || hold_vld_q;
  assign txd_o   = txd_q;
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tmr_load   = 1'b0;
    tmr_val    = BIT_LOAD;
    load_frame = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (hold_vld_q) load_frame = 1'b1;
      end
      START: begin
        if (tmr_done) begin
          txd_d    = shift_q[0];
          tmr_load = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            txd_d   = 1'b1;
            tmr_val = STOP_LOAD;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_d[0];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        txd_d = 1'b1;
        // A waiting byte starts on the very edge the stop period ends.
        if (tmr_done) begin
          if (hold_vld_q) load_frame = 1'b1;
          else            state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (load_frame) begin
      shift_d    = hold_q;
      hold_vld_d = 1'b0;
      bit_idx_d  = '0;
      tmr_load   = 1'b1;
      tmr_val    = BIT_LOAD;
      txd_d      = 1'b0;
      state_d    = START;
    end

    // accept needs an empty holder and load_frame a full one, so they never collide.
    if (accept) begin
      hold_d     = data_i;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      txd_q      <= 1'b1;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_alt.sv
// Bench for uart_tx_alt: one instance with one stop bit, one with two stop bits.
// Stimulus pushes expected frames (byte plus required start cycle) into a queue
// per instance; a line monitor decodes txd_o cycle by cycle and checks each frame.
module tb_uart_tx_alt;

  localparam int CLK  = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int PW   = 16;
  localparam int LAT  = -1;   // start expected one edge after the handshake
  localparam int DC   = -2;   // start cycle not checked

  typedef struct {
    logic [7:0] d;
    int         t_start;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_n, vld, rdy_w, txd_w, busy_w;
  logic [7:0] dat0, dat1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  uart_tx_alt #(.BAUD_RATE(BAUD), .DATA_WIDTH(8), .CLK_SPEED(CLK), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .data_i(dat0), .valid_i(vld[0]),
    .ready_o(rdy_w[0]), .txd_o(txd_w[0]), .busy_o(busy_w[0])
  );

  uart_tx_alt #(.BAUD_RATE(BAUD), .DATA_WIDTH(8), .CLK_SPEED(CLK), .STOP_BITS(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .data_i(dat1), .valid_i(vld[1]),
    .ready_o(rdy_w[1]), .txd_o(txd_w[1]), .busy_o(busy_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d, input int t_start);
    exp_t e;
    e.d = d;
    e.t_start = t_start;
    if (idx == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  // Decode one line; every level of a frame must hold for its full bit period.
  task automatic monitor(input int idx, input int stops);
    int         nbits;
    int         st;
    bit         aborted;
    logic       samp [0:175];
    logic [15:0] v;
    logic       lvl;
    exp_t       e;
    nbits = 1 + 8 + stops;
    forever begin
      @(negedge clk);
      if (rst_n[idx] === 1'b1 && txd_w[idx] === 1'b0) begin
        st = cyc;
        aborted = 1'b0;
        samp[0] = txd_w[idx];
        for (int i = 1; i < nbits * PW; i++) begin
          @(negedge clk);
          if (!rst_n[idx]) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = txd_w[idx];
        end
        if (!aborted) begin
          chk($sformatf("dut%0d frame_expected", idx),
              (idx == 0) ? 32'(sb0.size() != 0) : 32'(sb1.size() != 0), 1);
          if ((idx == 0 && sb0.size() != 0) || (idx == 1 && sb1.size() != 0)) begin
            e = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
            if (e.t_start >= 0)
              chk($sformatf("dut%0d byte %0h start_cycle", idx, e.d), st, e.t_start);
            for (int j = 0; j < nbits; j++) begin
              if (j == 0)      lvl = 1'b0;
              else if (j <= 8) lvl = e.d[j-1];
              else             lvl = 1'b1;
              for (int i = 0; i < PW; i++) v[15-i] = samp[j*PW+i];
              chk($sformatf("dut%0d byte %0h bit%0d levels", idx, e.d, j), v,
                  lvl ? 32'hFFFF : 32'h0);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 2);

  task automatic send(input int idx, input logic [7:0] d, input int t_start, output int hs);
    int n;
    @(negedge clk);
    vld[idx] = 1'b1;
    if (idx == 0) dat0 = d; else dat1 = d;
    n = 0;
    while (!rdy_w[idx] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d send %0h ready", idx, d), rdy_w[idx], 1);
    hs = cyc + 1;
    if (rdy_w[idx]) push(idx, d, (t_start == LAT) ? hs + 1 : t_start);
    @(posedge clk);
    #1;
    vld[idx] = 1'b0;
    if (idx == 0) dat0 = ~d; else dat1 = ~d;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    while ((((idx == 0) ? sb0.size() : sb1.size()) != 0 || busy_w[idx]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d drained", idx),
        32'((((idx == 0) ? sb0.size() : sb1.size()) == 0) && !busy_w[idx]), 1);
  endtask

  int hs, hs2, s1, c0, n_acc;
  logic [7:0] pat [4];

  initial begin
    rst_n = 2'b00;
    vld   = 2'b11;
    dat0  = 8'hEE;
    dat1  = 8'hEE;

    // Reset held with valid asserted: outputs idle, nothing captured.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs {txd,rdy,busy}", {txd_w, rdy_w, busy_w}, 6'b111100);
    end
    rst_n = 2'b11;
    vld   = 2'b00;
    @(negedge clk);
    chk("post_reset {txd,rdy,busy}", {txd_w, rdy_w, busy_w}, 6'b111100);
    repeat (3) @(negedge clk);

    // Single byte: latency, ready pulse, busy release at k+161.
    send(0, 8'hA5, LAT, hs);
    @(negedge clk);
    chk("ready_low_after_hs", rdy_w[0], 0);
    @(negedge clk);
    chk("ready_back_after_load", rdy_w[0], 1);
    wait_until(hs + 160);
    chk("busy_in_last_stop_cycle", busy_w[0], 1);
    @(negedge clk);
    chk("busy_clear_at_k161", busy_w[0], 0);
    repeat (10) @(negedge clk);

    // Back-to-back: second frame starts exactly 160 cycles after the first.
    send(0, 8'h00, LAT, hs);
    s1 = hs + 1;
    send(0, 8'hFF, s1 + 160, hs2);
    @(negedge clk);
    chk("ready_low_while_held", rdy_w[0], 0);
    wait_until(s1 + 159);
    chk("ready_low_before_frame2", rdy_w[0], 0);
    @(negedge clk);
    chk("ready_high_at_frame2_load", rdy_w[0], 1);
    drain(0);

    // Two stop bits: 176-cycle frame, queued frame follows at 176.
    send(1, 8'h55, LAT, hs);
    s1 = hs + 1;
    send(1, 8'h0F, s1 + 176, hs2);
    drain(1);

    // Reset during data bit 3 with a byte held: abort, discard, recover.
    send(0, 8'h12, LAT, hs);
    s1 = hs + 1;
    send(0, 8'h34, DC, hs2);
    wait_until(s1 + 70);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("abort_immediate {txd,rdy,busy}", {txd_w[0], rdy_w[0], busy_w[0]}, 3'b110);
    sb0.delete();
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    send(0, 8'h3C, LAT, hs);
    drain(0);
    repeat (200) @(negedge clk);

    // valid held high, data changing every cycle: only handshake-edge values go out.
    // Accepts land on loop steps 0, 2, 162, 322 (values i*37+5).
    pat[0] = 8'h05; pat[1] = 8'h4F; pat[2] = 8'h6F; pat[3] = 8'h8F;
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 4; k++) push(0, pat[k], c0 + 2 + 160 * k);
    n_acc = 0;
    vld[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 399) begin
        vld[0] = 1'b0;
      end else begin
        dat0 = 8'(i * 37 + 5);
        if (rdy_w[0]) n_acc++;
      end
    end
    chk("accept_count_with_valid_held", n_acc, 4);
    drain(0);
    repeat (200) @(negedge clk);
    chk("no_stray_frames_dut0", sb0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
